// File: rtl/aes_shift_rows_stream.sv
// aes_shift_rows_stream: column-serial ShiftRows / InvShiftRows engine.
// One 32-bit state column per beat in, NB-column blocks buffered in two
// ping-pong banks, row-rotated block out one column per beat.
// Optional feature macro: SHIFT_ROWS_MODE_SEL_EN. When defined, s_mode picks
// the direction per block (sampled on its first beat). When undefined, s_mode
// is ignored and every block is processed inverse.
module aes_shift_rows_stream #(
  parameter int NB = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [0:31] s_data,
  input  logic        s_mode,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [0:31] m_data,
  output logic        m_last
);

  localparam int CW = $clog2(NB);
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] NB_W     = SW'(NB);
  localparam logic [CW-1:0] LAST_COL = CW'(NB - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("aes_shift_rows_stream: NB must be 4, 6 or 8");
  end

  logic [0:31]   bank_q [2][NB];
  logic [0:31]   bank_d [2][NB];
  bank_st_e      st_q [2];
  bank_st_e      st_d [2];
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          rdy_en_q, rdy_en_d;
  logic          wr_fire, rd_fire, rd_inv;

`ifdef SHIFT_ROWS_MODE_SEL_EN
  logic mode_q [2];
  logic mode_d [2];
  assign rd_inv = mode_q[rd_ptr_q];
`else
  logic mode_unused;
  assign mode_unused = s_mode;
  assign rd_inv      = 1'b1;
`endif

  // Row rotation amount; the 256-bit block uses a wider spread for rows 2 and 3.
  function automatic logic [SW-1:0] row_shift(input logic [1:0] r);
    logic [SW-1:0] sh;
    case (r)
      2'd0:    sh = '0;
      2'd1:    sh = SW'(1);
      2'd2:    sh = (NB == 8) ? SW'(3) : SW'(2);
      default: sh = (NB == 8) ? SW'(4) : SW'(3);
    endcase
    return sh;
  endfunction

  // Source column for output column c, row r: one add/subtract then a single
  // conditional correction by NB keeps the result in 0..NB-1 without a divider.
  function automatic logic [CW-1:0] src_col(input logic [CW-1:0] c,
                                            input logic [1:0]    r,
                                            input logic          inv);
    logic [SW-1:0] s;
    if (inv) begin
      s = {1'b0, c} - row_shift(r);
      if (s[SW-1]) s = s + NB_W;
    end else begin
      s = {1'b0, c} + row_shift(r);
      if (s >= NB_W) s = s - NB_W;
    end
    return s[CW-1:0];
  endfunction

  // Handshake decode purely from registered bank state.
  always_comb begin
    s_ready = rdy_en_q && (st_q[wr_ptr_q] == EMPTY || st_q[wr_ptr_q] == FILLING);
    m_valid = (st_q[rd_ptr_q] == FULL || st_q[rd_ptr_q] == DRAINING);
    m_last  = m_valid && (rd_col_q == LAST_COL);
    wr_fire = s_valid && s_ready;
    rd_fire = m_valid && m_ready;
  end

  // Output column: per-row mux across the read bank, zero when idle.
  always_comb begin
    m_data = '0;
    if (m_valid) begin
      for (int r = 0; r < 4; r++) begin
        m_data[8*r +: 8] = bank_q[rd_ptr_q][src_col(rd_col_q, 2'(r), rd_inv)][8*r +: 8];
      end
    end
  end

  // Bank fill/drain sequencing and pointer/counter updates.
  always_comb begin
    bank_d   = bank_q;
    st_d     = st_q;
    wr_col_d = wr_col_q;
    rd_col_d = rd_col_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdy_en_d = 1'b1;
`ifdef SHIFT_ROWS_MODE_SEL_EN
    mode_d   = mode_q;
`endif
    // Write and read banks are necessarily different when both fire.
    if (wr_fire) begin
      bank_d[wr_ptr_q][wr_col_q] = s_data;
      if (wr_col_q == '0) begin
        st_d[wr_ptr_q] = FILLING;
`ifdef SHIFT_ROWS_MODE_SEL_EN
        mode_d[wr_ptr_q] = s_mode;
`endif
      end
      if (wr_col_q == LAST_COL) begin
        st_d[wr_ptr_q] = FULL;
        wr_col_d       = '0;
        wr_ptr_d       = ~wr_ptr_q;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end
    if (rd_fire) begin
      st_d[rd_ptr_q] = DRAINING;
      if (rd_col_q == LAST_COL) begin
        st_d[rd_ptr_q] = EMPTY;
        rd_col_d       = '0;
        rd_ptr_d       = ~rd_ptr_q;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  // State registers; reset discards every buffered column and block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b] <= EMPTY;
        for (int c = 0; c < NB; c++) bank_q[b][c] <= '0;
`ifdef SHIFT_ROWS_MODE_SEL_EN
        mode_q[b] <= 1'b0;
`endif
      end
      wr_col_q <= '0;
      rd_col_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      st_q     <= st_d;
`ifdef SHIFT_ROWS_MODE_SEL_EN
      mode_q   <= mode_d;
`endif
      wr_col_q <= wr_col_d;
      rd_col_q <= rd_col_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_stream.sv
// Testbench for aes_shift_rows_stream: three instances (NB = 4, 6, 8) driven
// by directed and randomized blocks, checked against a block-level reference
// model that rotates each captured block row by row.
`timescale 1ns/1ps
module tb_aes_shift_rows_stream;

  localparam int NI = 3;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid [NI];
  logic        s_ready [NI];
  logic [0:31] s_data  [NI];
  logic        s_mode  [NI];
  logic        m_valid [NI];
  logic        m_ready [NI];
  logic [0:31] m_data  [NI];
  logic        m_last  [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_shift_rows_stream #(.NB(4)) u_nb4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_mode(s_mode[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0])
  );
  aes_shift_rows_stream #(.NB(6)) u_nb6 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_mode(s_mode[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1])
  );
  aes_shift_rows_stream #(.NB(8)) u_nb8 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]), .s_mode(s_mode[2]),
    .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]), .m_last(m_last[2])
  );

  // ---------------- reference model ----------------
  function automatic int nb_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 6 : 8;
  endfunction

  function automatic int shift_of(input int nb, input int r);
    if (r == 0) return 0;
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic logic eff_mode(input logic m);
`ifdef SHIFT_ROWS_MODE_SEL_EN
    return m;
`else
    return m | 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0]  col_buf [NI][8][4];
  int          col_cnt [NI];
  logic        blk_mode [NI];
  exp_t        exp_q   [NI][$];
  logic [31:0] obs_log [NI][$];
  logic        hold_v  [NI];
  logic [31:0] hold_d  [NI];
  int          run_len [NI];
  int          max_run [NI];
  int          stall_cnt [NI];
  logic        rand_rdy = 1'b0;
  logic        rand_gap = 1'b0;

  exp_t        mon_e;
  logic [31:0] mon_w;
  int          mon_nb, mon_sh, mon_src;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        col_cnt[i] = 0;
        exp_q[i].delete();
        hold_v[i]  = 1'b0;
        run_len[i] = 0;
      end else begin
        if (hold_v[i]) begin
          chk($sformatf("hold_valid_%0d", i), {31'b0, m_valid[i]}, 32'd1);
          chk($sformatf("hold_data_%0d", i), m_data[i], hold_d[i]);
        end
        if (m_valid[i] && m_ready[i]) begin
          run_len[i]++;
          if (run_len[i] > max_run[i]) max_run[i] = run_len[i];
          if (exp_q[i].size() == 0) begin
            chk($sformatf("spurious_beat_%0d", i), {31'b0, m_valid[i]}, 32'd0);
          end else begin
            mon_e = exp_q[i].pop_front();
            chk($sformatf("data_%0d", i), m_data[i], mon_e.d);
            chk($sformatf("last_%0d", i), {31'b0, m_last[i]}, {31'b0, mon_e.l});
            obs_log[i].push_back(m_data[i]);
          end
        end else begin
          run_len[i] = 0;
        end
        hold_v[i] = m_valid[i] && !m_ready[i];
        hold_d[i] = m_data[i];
        if (s_valid[i] && s_ready[i]) begin
          if (col_cnt[i] == 0) blk_mode[i] = eff_mode(s_mode[i]);
          for (int r = 0; r < 4; r++) col_buf[i][col_cnt[i]][r] = s_data[i][8*r +: 8];
          col_cnt[i]++;
          mon_nb = nb_of(i);
          if (col_cnt[i] == mon_nb) begin
            for (int c = 0; c < mon_nb; c++) begin
              for (int r = 0; r < 4; r++) begin
                mon_sh  = shift_of(mon_nb, r);
                mon_src = blk_mode[i] ? (c - mon_sh + mon_nb) % mon_nb : (c + mon_sh) % mon_nb;
                mon_w[31-8*r -: 8] = col_buf[i][mon_src][r];
              end
              exp_q[i].push_back({mon_w, (c == mon_nb - 1)});
            end
            col_cnt[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_rdy(input int i);
    if (rand_rdy) m_ready[i] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_accept(input int i);
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (s_ready[i]) break;
      stall_cnt[i]++;
      guard++;
      if (guard > 300) begin
        chk($sformatf("accept_timeout_%0d", i), {31'b0, s_ready[i]}, 32'd1);
        break;
      end
      @(posedge clk); #1;
      tick_rdy(i);
    end
    @(posedge clk); #1;
    tick_rdy(i);
  endtask

  task automatic send_block(input int i, input logic mode, input int base,
                            input int ncols, input logic rnd);
    for (int c = 0; c < ncols; c++) begin
      if (rnd && rand_gap) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid[i] = 1'b0;
          @(posedge clk); #1;
          tick_rdy(i);
        end
      end
      s_valid[i] = 1'b1;
      s_mode[i]  = (c == 0) ? mode : ~mode;
      for (int r = 0; r < 4; r++)
        s_data[i][8*r +: 8] = rnd ? 8'($urandom) : 8'(base + 4*c + r);
      wait_accept(i);
    end
    s_valid[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i);
    int guard;
    guard = 0;
    while (exp_q[i].size() != 0 && guard < 1000) begin
      @(posedge clk); #1;
      tick_rdy(i);
      guard++;
    end
    chk($sformatf("drain_pending_%0d", i), 32'(exp_q[i].size()), 32'd0);
  endtask

  task automatic chk_idle(input string tag, input int i);
    chk({tag, "_s_ready"}, {31'b0, s_ready[i]}, 32'd0);
    chk({tag, "_m_valid"}, {31'b0, m_valid[i]}, 32'd0);
    chk({tag, "_m_data"},  m_data[i], 32'd0);
    chk({tag, "_m_last"},  {31'b0, m_last[i]}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] inv4 [4];
    logic [31:0] fwd4 [4];
    logic [31:0] col0_8;
    int          hi_cnt;

    inv4 = '{32'h000D0A07, 32'h04010E0B, 32'h0805020F, 32'h0C090603};
`ifdef SHIFT_ROWS_MODE_SEL_EN
    fwd4   = '{32'h00050A0F, 32'h04090E03, 32'h080D0207, 32'h0C01060B};
    col0_8 = 32'h00050E13;
`else
    fwd4   = inv4;
    col0_8 = 32'h001D1613;
`endif

    for (int i = 0; i < NI; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      s_mode[i]  = 1'b0;
      m_ready[i] = 1'b1;
      max_run[i] = 0;
      stall_cnt[i] = 0;
    end

    // reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk_idle($sformatf("reset_%0d", i), i);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'b0, s_ready[0]}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("ready_after_edge_%0d", i), {31'b0, s_ready[i]}, 32'd1);

    // NB=4 inverse, bytes 0x00..0x0F
    obs_log[0].delete();
    send_block(0, 1'b1, 0, 4, 1'b0);
    chk("latency_valid", {31'b0, m_valid[0]}, 32'd1);
    chk("latency_col0", m_data[0], inv4[0]);
    wait_drain(0);
    chk("inv4_count", 32'(obs_log[0].size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_log[0].size(); k++)
      chk($sformatf("inv4_col%0d", k), obs_log[0][k], inv4[k]);

    // NB=4 forward, same input
    obs_log[0].delete();
    send_block(0, 1'b0, 0, 4, 1'b0);
    wait_drain(0);
    chk("fwd4_count", 32'(obs_log[0].size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_log[0].size(); k++)
      chk($sformatf("fwd4_col%0d", k), obs_log[0][k], fwd4[k]);

    // NB=8 forward, bytes 0x00..0x1F
    obs_log[2].delete();
    send_block(2, 1'b0, 0, 8, 1'b0);
    wait_drain(2);
    chk("nb8_count", 32'(obs_log[2].size()), 32'd8);
    if (obs_log[2].size() > 0) chk("nb8_col0", obs_log[2][0], col0_8);

    // NB=4 three back-to-back blocks, alternating mode, m_ready high
    obs_log[0].delete();
    max_run[0] = 0;
    send_block(0, 1'b0, 8'h20, 4, 1'b0);
    stall_cnt[0] = 0;
    send_block(0, 1'b1, 8'h40, 4, 1'b0);
    send_block(0, 1'b0, 8'h60, 4, 1'b0);
    chk("b2b_stalls", 32'(stall_cnt[0]), 32'd0);
    wait_drain(0);
    chk("b2b_count", 32'(obs_log[0].size()), 32'd12);
    chk("b2b_run", 32'(max_run[0]), 32'd12);

    // NB=6 with m_ready held low: both banks fill, then back-pressure
    obs_log[1].delete();
    m_ready[1] = 1'b0;
    send_block(1, 1'b0, 8'h00, 6, 1'b0);
    send_block(1, 1'b1, 8'h30, 6, 1'b0);
    chk("nb6_ready_full", {31'b0, s_ready[1]}, 32'd0);
    hi_cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (s_ready[1] || !m_valid[1]) hi_cnt++;
    end
    chk("nb6_stall_hold", 32'(hi_cnt), 32'd0);
    m_ready[1] = 1'b1;
    wait_drain(1);
    chk("nb6_count", 32'(obs_log[1].size()), 32'd12);

    // reset mid-block with a full block pending
    m_ready[0] = 1'b0;
    send_block(0, 1'b1, 8'hA0, 4, 1'b0);
    send_block(0, 1'b1, 8'hC0, 2, 1'b0);
    chk("pre_reset_valid", {31'b0, m_valid[0]}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk_idle("midreset", 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready[0] = 1'b1;
    obs_log[0].delete();
    send_block(0, 1'b1, 0, 4, 1'b0);
    wait_drain(0);
    chk("post_reset_count", 32'(obs_log[0].size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_log[0].size(); k++)
      chk($sformatf("post_reset_col%0d", k), obs_log[0][k], inv4[k]);

    // randomized blocks with random gaps and back-pressure
    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NI; i++) send_block(i, 1'($urandom_range(0, 1)), 0, nb_of(i), 1'b1);
    end
    for (int i = 0; i < NI; i++) wait_drain(i);
    rand_rdy = 1'b0;
    rand_gap = 1'b0;
    for (int i = 0; i < NI; i++) m_ready[i] = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
